fetch_unit: RTL and testbench

Instruction-fetch stage of the multicycle MIPS datapath, directly downstream of the next-PC logic. Holds the architectural PC (word address, bits [31:2]), loads the next-PC value when the controller commits an instruction, and issues one instruction-memory read per instruction. It latches the returned word into the instruction register and hands it to the decode/control FSM over a valid/take handshake. A watchdog flags an instruction-memory read that never completes.

---
 rtl/mips_pkg.sv | 17 +
 rtl/fetch_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_unit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS datapath: widths, reset PC and fetch FSM encoding.
package mips_pkg;

    localparam int PC_W    = 30;
    localparam int INSTR_W = 32;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 30'h0C00;

    typedef logic [2:0] fetch_state_t;

    localparam fetch_state_t ST_ISSUE = 3'd0;
    localparam fetch_state_t ST_WAIT  = 3'd1;
    localparam fetch_state_t ST_HOLD  = 3'd2;
    localparam fetch_state_t ST_EXEC  = 3'd3;
    localparam fetch_state_t ST_ERR   = 3'd4;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: holds PC, issues one imem read per instruction, latches IR for decode.
// Latency: req one cycle after ISSUE; ir_valid one cycle after the accepted ack.
// Backpressure: IR held in HOLD until ir_take; a single read outstanding; watchdog -> sticky ERR.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     TIMEOUT  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    npc,
    input  logic               pc_wr,
    output logic [PC_W-1:0]    pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    input  logic               ir_take,
    output logic               fetch_err
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    fetch_state_t state, state_nxt;

    logic               kill, kill_nxt;
    logic [7:0]         cnt, cnt_nxt;
    logic [PC_W-1:0]    pc_nxt, addr_nxt;
    logic               req_nxt, ir_valid_nxt, err_nxt;
    logic [INSTR_W-1:0] ir_nxt;

    // A redirect in the same cycle as the ack also kills the returning word.
    logic drop_ack;
    assign drop_ack = kill | pc_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_ISSUE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ISSUE: begin
                if (!pc_wr) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_ack) begin
                    state_nxt = drop_ack ? ST_ISSUE : ST_HOLD;
                end else if (cnt == TO_LAST) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_HOLD: begin
                if (pc_wr)        state_nxt = ST_ISSUE;
                else if (ir_take) state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                if (pc_wr) state_nxt = ST_ISSUE;
            end
            ST_ERR:  state_nxt = ST_ERR;
            default: state_nxt = ST_ISSUE;
        endcase
    end

    always_comb begin
        pc_nxt       = pc;
        req_nxt      = imem_req;
        addr_nxt     = imem_addr;
        ir_nxt       = ir;
        ir_valid_nxt = ir_valid;
        err_nxt      = fetch_err;
        kill_nxt     = kill;
        cnt_nxt      = cnt;

        if (pc_wr && (state != ST_ERR)) pc_nxt = npc;

        case (state)
            ST_ISSUE: begin
                // A commit landing here defers the issue so the read uses the new PC.
                if (!pc_wr) begin
                    req_nxt  = 1'b1;
                    addr_nxt = pc;
                    cnt_nxt  = 8'd0;
                end
            end
            ST_WAIT: begin
                if (imem_ack) begin
                    req_nxt = 1'b0;
                    if (drop_ack) begin
                        kill_nxt = 1'b0;
                    end else begin
                        ir_nxt       = imem_rdata;
                        ir_valid_nxt = 1'b1;
                    end
                end else if (cnt == TO_LAST) begin
                    req_nxt  = 1'b0;
                    err_nxt  = 1'b1;
                    kill_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                    if (pc_wr) kill_nxt = 1'b1;
                end
            end
            ST_HOLD: begin
                if (pc_wr || ir_take) ir_valid_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            ir        <= '0;
            ir_valid  <= 1'b0;
            fetch_err <= 1'b0;
            kill      <= 1'b0;
            cnt       <= 8'd0;
        end else begin
            pc        <= pc_nxt;
            imem_req  <= req_nxt;
            imem_addr <= addr_nxt;
            ir        <= ir_nxt;
            ir_valid  <= ir_valid_nxt;
            fetch_err <= err_nxt;
            kill      <= kill_nxt;
            cnt       <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 4-cycle watchdog; expected values computed by hand.
module tb_fetch_unit;
    import mips_pkg::*;

    logic               clk;
    logic               rst;
    logic [PC_W-1:0]    npc;
    logic               pc_wr;
    logic [PC_W-1:0]    pc;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] ir;
    logic               ir_valid;
    logic               ir_take;
    logic               fetch_err;

    int n_vec = 0;
    int n_err = 0;

    fetch_unit #(.RESET_PC(30'h0C00), .TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .npc        (npc),
        .pc_wr      (pc_wr),
        .pc         (pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .ir_valid   (ir_valid),
        .ir_take    (ir_take),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled and inputs changed 1ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".pc"},       32'(pc),        32'h0C00);
        chk({tag, ".req"},      32'(imem_req),  32'h0);
        chk({tag, ".addr"},     32'(imem_addr), 32'h0);
        chk({tag, ".ir"},       ir,             32'h0);
        chk({tag, ".ir_valid"}, 32'(ir_valid),  32'h0);
        chk({tag, ".err"},      32'(fetch_err), 32'h0);
    endtask

    initial begin
        rst = 1'b1; npc = '0; pc_wr = 1'b0; imem_ack = 1'b0;
        imem_rdata = '0; ir_take = 1'b0;
        cyc(); cyc();
        chk_reset("rst0");

        // Zero-wait first fetch from the reset PC.
        rst = 1'b0; imem_rdata = 32'h2408_0001;
        cyc();
        chk("f1.req",  32'(imem_req),  32'h1);
        chk("f1.addr", 32'(imem_addr), 32'h0C00);
        chk("f1.vld0", 32'(ir_valid),  32'h0);
        imem_ack = 1'b1;
        cyc();
        chk("f1.vld",  32'(ir_valid), 32'h1);
        chk("f1.ir",   ir,            32'h2408_0001);
        chk("f1.req0", 32'(imem_req), 32'h0);
        imem_ack = 1'b0;
        cyc();
        chk("hold.vld", 32'(ir_valid), 32'h1);

        // Decode takes, then commit to 0x0C01.
        ir_take = 1'b1;
        cyc();
        chk("take.vld", 32'(ir_valid), 32'h0);
        chk("take.ir",  ir,            32'h2408_0001);
        ir_take = 1'b0; pc_wr = 1'b1; npc = 30'h0C01;
        cyc();
        chk("c1.pc",  32'(pc),       32'h0C01);
        chk("c1.req", 32'(imem_req), 32'h0);
        pc_wr = 1'b0;
        cyc();
        chk("f2.req",  32'(imem_req),  32'h1);
        chk("f2.addr", 32'(imem_addr), 32'h0C01);
        imem_rdata = 32'h8C09_0004;
        cyc();
        chk("f2.wait", 32'(imem_req), 32'h1);
        imem_ack = 1'b1;
        cyc();
        chk("f2.ir",  ir,            32'h8C09_0004);
        chk("f2.vld", 32'(ir_valid), 32'h1);
        imem_ack = 1'b0;

        // Redirect and take in the same HOLD cycle: redirect wins.
        pc_wr = 1'b1; ir_take = 1'b1; npc = 30'h0C02;
        cyc();
        chk("rt.vld", 32'(ir_valid), 32'h0);
        chk("rt.pc",  32'(pc),       32'h0C02);
        chk("rt.req", 32'(imem_req), 32'h0);
        pc_wr = 1'b0; ir_take = 1'b0;
        cyc();
        chk("f3.req",  32'(imem_req),  32'h1);
        chk("f3.addr", 32'(imem_addr), 32'h0C02);

        // Redirect while WAIT: returning word is dropped, refetch from new PC.
        pc_wr = 1'b1; npc = 30'h0D00;
        cyc();
        chk("k.pc",   32'(pc),        32'h0D00);
        chk("k.addr", 32'(imem_addr), 32'h0C02);
        pc_wr = 1'b0;
        cyc(); cyc();
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        cyc();
        chk("k.req0", 32'(imem_req), 32'h0);
        chk("k.vld",  32'(ir_valid), 32'h0);
        chk("k.ir",   ir,            32'h8C09_0004);
        imem_ack = 1'b0;
        cyc();
        chk("k.req",  32'(imem_req),  32'h1);
        chk("k.addr2", 32'(imem_addr), 32'h0D00);

        // No ack: watchdog fires exactly 4 cycles after req rose.
        cyc(); cyc(); cyc();
        chk("to.req3", 32'(imem_req),  32'h1);
        chk("to.err3", 32'(fetch_err), 32'h0);
        cyc();
        chk("to.err", 32'(fetch_err), 32'h1);
        chk("to.req", 32'(imem_req),  32'h0);
        imem_ack = 1'b1; pc_wr = 1'b1; npc = 30'h0123; ir_take = 1'b1;
        cyc(); cyc();
        chk("err.err", 32'(fetch_err), 32'h1);
        chk("err.req", 32'(imem_req),  32'h0);
        chk("err.pc",  32'(pc),        32'h0D00);
        chk("err.vld", 32'(ir_valid),  32'h0);
        chk("err.ir",  ir,             32'h8C09_0004);
        imem_ack = 1'b0; pc_wr = 1'b0; ir_take = 1'b0;

        // Reset clears ERR; then reset during WAIT with a coincident ack.
        rst = 1'b1;
        cyc();
        chk_reset("rst1");
        rst = 1'b0;
        cyc();
        chk("r.req",  32'(imem_req),  32'h1);
        chk("r.addr", 32'(imem_addr), 32'h0C00);
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
        cyc();
        chk_reset("rst2");
        rst = 1'b0;
        cyc();
        chk("late.req", 32'(imem_req), 32'h1);
        chk("late.vld", 32'(ir_valid), 32'h0);
        chk("late.ir",  ir,            32'h0);
        imem_ack = 1'b0;
        cyc();
        chk("late.vld2", 32'(ir_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
